fetch_ctrl: RTL and testbench

- Sequencer for the instruction-fetch stage: drives the program counter's enable/select/target and the IF/ID and ID/EX pipeline-register controls.
- Handles start-up on trigger, per-fetch instruction-memory wait states, load-use stalls, taken-branch redirect with flush, and halt.
- Sits between the hazard unit / execute stage and the fetch stage plus its pipeline registers.

---
 rtl/fetch_ctrl.sv | 133 +++++++++++++
 tb/tb_fetch_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC enable/select, IF/ID and ID/EX controls with memory
// wait states, load-use stalls, branch redirect and halt. Optional perf counters: FETCH_CTRL_PERF_EN.
module fetch_ctrl #(
   parameter int PC_WIDTH    = 32,
   parameter int MEM_LATENCY = 0,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 trigger,
   input  logic                 stall_req,
   input  logic                 branch_taken,
   input  logic [PC_WIDTH-1:0]  branch_target,
   input  logic                 halt_req,
   output logic                 pc_en,
   output logic                 pc_src,
   output logic [PC_WIDTH-1:0]  pc_branch,
   output logic                 if_id_en,
   output logic                 if_id_flush,
   output logic                 id_ex_flush,
   output logic                 running,
`ifdef FETCH_CTRL_PERF_EN
   output logic [CNT_WIDTH-1:0] perf_stall_cycles,
   output logic [CNT_WIDTH-1:0] perf_wait_cycles,
   output logic [CNT_WIDTH-1:0] perf_flushes,
`endif
   output logic                 halted
);

   typedef enum logic [1:0] {IDLE, FETCH, WAIT, HALT} state_t;

   localparam logic [2:0] LAT = 3'(MEM_LATENCY);

   if (MEM_LATENCY < 0 || MEM_LATENCY > 7 || CNT_WIDTH < 1) begin : g_bad_param
      $error("fetch_ctrl: MEM_LATENCY must be 0..7 and CNT_WIDTH at least 1");
   end

   state_t     state, next_state;
   logic [2:0] wcnt, next_wcnt;

   // A fetch completes in FETCH only with zero latency, or in WAIT once wcnt reaches LAT.
   always_comb begin
      next_state  = state;
      next_wcnt   = wcnt;
      pc_en       = 1'b0;
      pc_src      = 1'b0;
      pc_branch   = '0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      running     = 1'b0;
      halted      = 1'b0;
      case (state)
         IDLE: begin
            if (trigger) next_state = FETCH;
         end
         FETCH, WAIT: begin
            running = 1'b1;
            if (halt_req) begin
               next_state = HALT;
               next_wcnt  = 3'd0;
            end else if (branch_taken) begin
               pc_en       = 1'b1;
               pc_src      = 1'b1;
               pc_branch   = branch_target;
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
               // The redirect cycle itself counts as the first cycle of the new fetch.
               if (LAT == 3'd0) begin
                  next_state = FETCH;
                  next_wcnt  = 3'd0;
               end else begin
                  next_state = WAIT;
                  next_wcnt  = 3'd1;
               end
            end else if (stall_req) begin
               id_ex_flush = 1'b1;
            end else if ((state == WAIT) ? (wcnt == LAT) : (LAT == 3'd0)) begin
               pc_en      = 1'b1;
               if_id_en   = 1'b1;
               next_state = FETCH;
               next_wcnt  = 3'd0;
            end else begin
               id_ex_flush = 1'b1;
               next_state  = WAIT;
               next_wcnt   = (state == FETCH) ? 3'd1 : wcnt + 3'd1;
            end
         end
         HALT: begin
            halted = 1'b1;
         end
         default: begin
            next_state = IDLE;
            next_wcnt  = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         wcnt  <= 3'd0;
      end else begin
         state <= next_state;
         wcnt  <= next_wcnt;
      end
   end

`ifdef FETCH_CTRL_PERF_EN
   logic stall_hit, wait_hit, redirect_hit;

   assign stall_hit    = running && !halt_req && !branch_taken && stall_req;
   assign wait_hit     = (state == WAIT) && !pc_en;
   assign redirect_hit = running && !halt_req && branch_taken;

   // Saturating event counters; they stick at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_cycles <= '0;
         perf_wait_cycles  <= '0;
         perf_flushes      <= '0;
      end else begin
         if (stall_hit && !(&perf_stall_cycles))
            perf_stall_cycles <= perf_stall_cycles + 1'b1;
         if (wait_hit && !(&perf_wait_cycles))
            perf_wait_cycles <= perf_wait_cycles + 1'b1;
         if (redirect_hit && !(&perf_flushes))
            perf_flushes <= perf_flushes + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: three instances (latency 0, 2, 3) share one stimulus
// stream and are compared every cycle against a fetch-progress model, plus vector table and corner cases.
module tb_fetch_ctrl;

   localparam int NDUT = 3;

   logic        clk = 1'b0;
   logic        rst, trigger, stall_req, branch_taken, halt_req;
   logic [31:0] branch_target;

   logic        pc_en [NDUT];
   logic        pc_src [NDUT];
   logic [31:0] pc_branch [NDUT];
   logic        if_id_en [NDUT];
   logic        if_id_flush [NDUT];
   logic        id_ex_flush [NDUT];
   logic        running [NDUT];
   logic        halted [NDUT];
`ifdef FETCH_CTRL_PERF_EN
   logic [31:0] perf_stall [NDUT];
   logic [31:0] perf_wait [NDUT];
   logic [31:0] perf_flush [NDUT];
`endif

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      fetch_ctrl #(
         .PC_WIDTH(32),
         .MEM_LATENCY(g == 0 ? 0 : (g == 1 ? 2 : 3)),
         .CNT_WIDTH(32)
      ) dut (
         .clk(clk),
         .rst(rst),
         .trigger(trigger),
         .stall_req(stall_req),
         .branch_taken(branch_taken),
         .branch_target(branch_target),
         .halt_req(halt_req),
         .pc_en(pc_en[g]),
         .pc_src(pc_src[g]),
         .pc_branch(pc_branch[g]),
         .if_id_en(if_id_en[g]),
         .if_id_flush(if_id_flush[g]),
         .id_ex_flush(id_ex_flush[g]),
         .running(running[g]),
`ifdef FETCH_CTRL_PERF_EN
         .perf_stall_cycles(perf_stall[g]),
         .perf_wait_cycles(perf_wait[g]),
         .perf_flushes(perf_flush[g]),
`endif
         .halted(halted[g])
      );
   end

   // Reference model: mode 0 idle, 1 running, 2 halted; prog = cycles already spent on
   // the current fetch (the fetch completes in the cycle where prog equals the latency).
   int     m_mode [NDUT];
   int     m_prog [NDUT];
   longint m_stall [NDUT];
   longint m_wait [NDUT];
   longint m_flush [NDUT];

   function automatic int lat_of(int i);
      return (i == 0) ? 0 : ((i == 1) ? 2 : 3);
   endfunction

   function automatic logic [6:0] dut_flags(int i);
      return {pc_en[i], pc_src[i], if_id_en[i], if_id_flush[i], id_ex_flush[i], running[i], halted[i]};
   endfunction

   // Expected flags ordered {pc_en, pc_src, if_id_en, if_id_flush, id_ex_flush, running, halted}.
   task automatic model_expect(input int i, output logic [6:0] f, output logic [31:0] pcb);
      f   = 7'b0;
      pcb = 32'h0;
      if (m_mode[i] == 2) f = 7'b0000001;
      else if (m_mode[i] == 1) begin
         if (halt_req)          f = 7'b0000010;
         else if (branch_taken) begin f = 7'b1101110; pcb = branch_target; end
         else if (stall_req)    f = 7'b0000110;
         else if (m_prog[i] == lat_of(i)) f = 7'b1010010;
         else                   f = 7'b0000110;
      end
   endtask

   task automatic model_advance();
      for (int i = 0; i < NDUT; i++) begin
         if (rst) begin
            m_mode[i] = 0; m_prog[i] = 0;
            m_stall[i] = 0; m_wait[i] = 0; m_flush[i] = 0;
         end else if (m_mode[i] == 0) begin
            if (trigger) begin m_mode[i] = 1; m_prog[i] = 0; end
         end else if (m_mode[i] == 1) begin
            if (halt_req) begin
               if (m_prog[i] > 0) m_wait[i]++;
               m_mode[i] = 2; m_prog[i] = 0;
            end else if (branch_taken) begin
               m_flush[i]++;
               m_prog[i] = (lat_of(i) > 0) ? 1 : 0;
            end else if (stall_req) begin
               m_stall[i]++;
               if (m_prog[i] > 0) m_wait[i]++;
            end else if (m_prog[i] == lat_of(i)) begin
               m_prog[i] = 0;
            end else begin
               if (m_prog[i] > 0) m_wait[i]++;
               m_prog[i]++;
            end
         end
      end
   endtask

   task automatic check_output();
      logic [6:0]  ef;
      logic [31:0] ep;
      for (int i = 0; i < NDUT; i++) begin
         model_expect(i, ef, ep);
         n_checks++;
         if ({dut_flags(i), pc_branch[i]} !== {ef, ep}) begin
            n_fails++;
            $display("[TB] FAIL model_lat%0d t=%0t: got flags=%b pc_branch=%h, expected flags=%b pc_branch=%h",
                     lat_of(i), $time, dut_flags(i), pc_branch[i], ef, ep);
         end
`ifdef FETCH_CTRL_PERF_EN
         n_checks++;
         if ({perf_stall[i], perf_wait[i], perf_flush[i]} !==
             {m_stall[i][31:0], m_wait[i][31:0], m_flush[i][31:0]}) begin
            n_fails++;
            $display("[TB] FAIL perf_lat%0d t=%0t: got %0d/%0d/%0d, expected %0d/%0d/%0d",
                     lat_of(i), $time, perf_stall[i], perf_wait[i], perf_flush[i],
                     m_stall[i], m_wait[i], m_flush[i]);
         end
`endif
      end
   endtask

   // Drive at posedge+1, check at mid-cycle; tick() then clocks the DUTs and the model.
   task automatic apply_stimulus(input logic r, input logic t, input logic s, input logic b,
                                 input logic h, input logic [31:0] tgt);
      rst = r; trigger = t; stall_req = s; branch_taken = b; halt_req = h; branch_target = tgt;
      #4;
      check_output();
   endtask

   task automatic tick();
      @(posedge clk);
      model_advance();
      #1;
   endtask

   task automatic check_value(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
      end
   endtask

   typedef struct {
      logic        r, t, s, b, h;
      logic [31:0] tgt;
      logic [6:0]  flags;
      logic [31:0] pcb;
   } vec_t;

   vec_t vecs [15];

   initial begin
      // Hand-derived expectations for the latency-2 instance.
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    7'b0000000, 32'h0};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    7'b0000000, 32'h0};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    7'b0000110, 32'h0};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    7'b0000110, 32'h0};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    7'b1010010, 32'h0};
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    7'b0000110, 32'h0};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    7'b0000110, 32'h0};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    7'b0000110, 32'h0};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40,   7'b1101110, 32'h40};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1234, 7'b0000110, 32'h0};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    7'b1010010, 32'h0};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,    7'b0000010, 32'h0};
      vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    7'b0000001, 32'h0};
      vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    7'b0000001, 32'h0};
      vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    7'b0000000, 32'h0};

      rst = 1'b1; trigger = 1'b0; stall_req = 1'b0; branch_taken = 1'b0; halt_req = 1'b0;
      branch_target = 32'h0;
      for (int i = 0; i < NDUT; i++) begin
         m_mode[i] = 0; m_prog[i] = 0; m_stall[i] = 0; m_wait[i] = 0; m_flush[i] = 0;
      end
      @(posedge clk);
      #1;

      for (int v = 0; v < 15; v++) begin
         apply_stimulus(vecs[v].r, vecs[v].t, vecs[v].s, vecs[v].b, vecs[v].h, vecs[v].tgt);
         check_value($sformatf("vec%0d_flags", v), 64'(dut_flags(1)), 64'(vecs[v].flags));
         check_value($sformatf("vec%0d_pc_branch", v), 64'(pc_branch[1]), 64'(vecs[v].pcb));
         tick();
      end

      // Zero-latency start-up: every cycle after the trigger fetches.
      begin
         int fetches = 0;
         apply_stimulus(1, 0, 0, 0, 0, 0); tick();
         apply_stimulus(1, 0, 0, 0, 0, 0); tick();
         apply_stimulus(0, 1, 0, 0, 0, 0); tick();
         for (int c = 0; c < 5; c++) begin
            apply_stimulus(0, 0, 0, 0, 0, 0);
            if (pc_en[0] && if_id_en[0] && running[0]) fetches++;
            tick();
         end
         check_value("startup_lat0_fetches", 64'(fetches), 64'd5);
      end

      // Latency-3 branch at wcnt=2: redirect now, next completion three cycles later.
      begin
         int found = -1;
         apply_stimulus(1, 0, 0, 0, 0, 0); tick();
         apply_stimulus(0, 1, 0, 0, 0, 0); tick();
         apply_stimulus(0, 0, 0, 0, 0, 0); tick();
         apply_stimulus(0, 0, 0, 0, 0, 0); tick();
         apply_stimulus(0, 0, 0, 1, 0, 32'h80);
         check_value("midwait_redirect", 64'({pc_en[2], pc_src[2], pc_branch[2]}), {31'h0, 1'b1, 1'b1, 32'h80});
         tick();
         for (int c = 0; c < 6; c++) begin
            apply_stimulus(0, 0, 0, 0, 0, 0);
            if (pc_en[2] && found < 0) found = c;
            tick();
         end
         check_value("midwait_next_pc_en", 64'(found), 64'd2);
      end

      // Randomised traffic against the model.
      apply_stimulus(1, 0, 0, 0, 0, 0); tick();
      for (int c = 0; c < 400; c++) begin
         apply_stimulus($urandom_range(29) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
                        $urandom_range(5) == 0, $urandom_range(39) == 0, $urandom);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
